// File: rtl/unidade_busca_decodifica_pkg.sv
// Shared definitions for the fetch/decode/sequencing stage: FSM states,
// opcode constants, instruction field positions and opcode class helpers.
package unidade_busca_decodifica_pkg;

  // Sequencer states, one per phase of the instruction cycle.
  typedef enum logic [2:0] {
    BUSCA      = 3'd0,
    DECODIFICA = 3'd1,
    EXECUTA    = 3'd2,
    ESCRITA    = 3'd3,
    PARADO     = 3'd4
  } estado_t;

  // Opcodes with special sequencing; 0x1..0xB are plain write-ra operations.
  localparam logic [3:0] OPC_NOP      = 4'h0;
  localparam logic [3:0] OPC_STORE    = 4'hC;
  localparam logic [3:0] OPC_BRANCH_Z = 4'hD;
  localparam logic [3:0] OPC_JUMP     = 4'hE;
  localparam logic [3:0] OPC_HALT     = 4'hF;

  // Instruction word layout: [7:4] opcode, [3:2] ra, [1:0] rb.
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RA_MSB  = 3;
  localparam int RA_LSB  = 2;
  localparam int RB_MSB  = 1;
  localparam int RB_LSB  = 0;

  // True for opcodes whose result is written back into register ra.
  // Everything from STORE upward (store, branch, jump, halt) and NOP do not write.
  function automatic logic escreve_reg(input logic [3:0] op);
    return (op != OPC_NOP) && (op < OPC_STORE);
  endfunction

  // True for the opcodes that may redirect the PC when the ALU reports a taken branch.
  function automatic logic eh_desvio(input logic [3:0] op);
    return (op == OPC_BRANCH_Z) || (op == OPC_JUMP);
  endfunction

endpackage

// File: rtl/unidade_busca_decodifica_if.sv
// Instruction memory fetch bus: request/address out, acknowledge/data back.
// The fetch unit is the master; the instruction memory is the slave.
interface unidade_busca_decodifica_if #(
  parameter int PC_W = 8
);

  logic            mem_req;   // fetch request
  logic [PC_W-1:0] mem_addr;  // fetch address, equals pc while mem_req is high
  logic            mem_ack;   // mem_dado is valid this cycle
  logic [7:0]      mem_dado;  // fetched instruction byte

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_dado
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_dado
  );

endinterface

// File: rtl/unidade_busca_decodifica_decodifica_campos.sv
// Combinational decode of the instruction register into register numbers
// and opcode class flags.
// Build option A0_REMAP_EN: when defined, a 2'b11 field selects register 7
// (a0) instead of register 3 on all three register-number outputs.
module decodifica_campos
  import unidade_busca_decodifica_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [7:0]       ir_i,
  output logic [3:0]       opcode_o,
  output logic [REG_W-1:0] reg_lido1_o,
  output logic [REG_W-1:0] reg_lido2_o,
  output logic [REG_W-1:0] reg_escrito_o,
  output logic             eh_nop_o,
  output logic             eh_halt_o,
  output logic             eh_desvio_o,
  output logic             escreve_o
);

  // Index 0 is the ra field, index 1 the rb field.
  logic [1:0]       campo   [2];
  logic [REG_W-1:0] num_reg [2];

  assign campo[0] = ir_i[RA_MSB:RA_LSB];
  assign campo[1] = ir_i[RB_MSB:RB_LSB];

  // Map each 2-bit register field onto the bank's register numbering.
  for (genvar gi = 0; gi < 2; gi++) begin : g_campo
`ifdef A0_REMAP_EN
    // Field value 3 is redirected to a0 (register 7); register 3 is then
    // unreachable from instruction fields.
    assign num_reg[gi] = (campo[gi] == 2'b11) ? REG_W'(7) : REG_W'(campo[gi]);
`else
    assign num_reg[gi] = REG_W'(campo[gi]);
`endif
  end

  // ra is both the first read operand and the write destination.
  assign reg_lido1_o   = num_reg[0];
  assign reg_escrito_o = num_reg[0];
  assign reg_lido2_o   = num_reg[1];

  // Opcode and its sequencing class.
  assign opcode_o    = ir_i[OPC_MSB:OPC_LSB];
  assign eh_nop_o    = (opcode_o == OPC_NOP);
  assign eh_halt_o   = (opcode_o == OPC_HALT);
  assign eh_desvio_o = eh_desvio(opcode_o);
  assign escreve_o   = escreve_reg(opcode_o);

endmodule

// File: rtl/unidade_busca_decodifica.sv
// Multi-cycle fetch/decode/sequencing stage in front of the register bank.
// Fetches 8-bit instructions over a req/ack bus, holds them in IR, drives the
// bank's register numbers and write strobe, starts the ALU stage and applies
// taken branches to the PC.
// Build option A0_REMAP_EN: register field 2'b11 addresses register 7 (a0).
module unidade_busca_decodifica
  import unidade_busca_decodifica_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int PC_RESET = 0,
  parameter int REG_W    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  unidade_busca_decodifica_if.master mem,
  output logic [REG_W-1:0]           RegLido1,
  output logic [REG_W-1:0]           RegLido2,
  output logic [REG_W-1:0]           RegEscrito,
  output logic                       EscReg,
  output logic [3:0]                 opcode,
  output logic                       exec_inicio,
  input  logic                       exec_pronto,
  input  logic                       desvio_tomado,
  input  logic [PC_W-1:0]            desvio_alvo,
  output logic [PC_W-1:0]            pc,
  output logic                       parado
);

  estado_t         estado_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_inc_d;
  logic [7:0]      ir_q;
  logic            mem_req_q;
  logic            esc_reg_q;
  logic            exec_inicio_q;
  logic            parado_q;

  logic            eh_nop;
  logic            eh_halt;
  logic            eh_desvio_op;
  logic            escreve;

  // Sequential PC advance; the natural width makes all-ones wrap to zero.
  assign pc_inc_d = pc_q + PC_W'(1);

  decodifica_campos #(
    .REG_W (REG_W)
  ) u_decodifica_campos (
    .ir_i          (ir_q),
    .opcode_o      (opcode),
    .reg_lido1_o   (RegLido1),
    .reg_lido2_o   (RegLido2),
    .reg_escrito_o (RegEscrito),
    .eh_nop_o      (eh_nop),
    .eh_halt_o     (eh_halt),
    .eh_desvio_o   (eh_desvio_op),
    .escreve_o     (escreve)
  );

  // Instruction sequencer with registered control outputs.
  // mem_req is a register: it is raised on every entry into BUSCA, and after
  // reset (which clears it) BUSCA spends one cycle raising it before fetching.
  // EscReg and exec_inicio default low so each is a single-cycle pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= BUSCA;
      pc_q          <= PC_W'(PC_RESET);
      ir_q          <= '0;
      mem_req_q     <= 1'b0;
      esc_reg_q     <= 1'b0;
      exec_inicio_q <= 1'b0;
      parado_q      <= 1'b0;
    end else begin
      esc_reg_q     <= 1'b0;
      exec_inicio_q <= 1'b0;
      case (estado_q)
        BUSCA: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem.mem_ack) begin
            // Ack may come in the same cycle as the request.
            ir_q      <= mem.mem_dado;
            pc_q      <= pc_inc_d;
            mem_req_q <= 1'b0;
            estado_q  <= DECODIFICA;
          end
        end
        DECODIFICA: begin
          if (eh_halt) begin
            estado_q <= PARADO;
            parado_q <= 1'b1;
          end else if (eh_nop) begin
            estado_q  <= BUSCA;
            mem_req_q <= 1'b1;
          end else begin
            estado_q      <= EXECUTA;
            exec_inicio_q <= 1'b1;
          end
        end
        EXECUTA: begin
          if (exec_pronto) begin
            // A taken branch replaces the already-incremented PC.
            if (eh_desvio_op && desvio_tomado) begin
              pc_q <= desvio_alvo;
            end
            if (escreve) begin
              estado_q  <= ESCRITA;
              esc_reg_q <= 1'b1;
            end else begin
              estado_q  <= BUSCA;
              mem_req_q <= 1'b1;
            end
          end
        end
        ESCRITA: begin
          estado_q  <= BUSCA;
          mem_req_q <= 1'b1;
        end
        PARADO: begin
          // Only reset leaves this state.
          parado_q  <= 1'b1;
          mem_req_q <= 1'b0;
        end
        default: begin
          estado_q  <= BUSCA;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc_q;
  assign EscReg       = esc_reg_q;
  assign exec_inicio  = exec_inicio_q;
  assign pc           = pc_q;
  assign parado       = parado_q;

endmodule
